// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one SRAM port between scan-out reads, clear
// sweeps and FIFO-buffered, bounds-checked line-pixel writes, with a starvation guard.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module fb_port_arbiter #(
    parameter int                   WIDTH       = `WIDTH,
    parameter int                   HEIGHT      = `HEIGHT,
    parameter int                   ADDR_W      = 19,
    parameter int                   COLOR_W     = 24,
    parameter logic [COLOR_W-1:0]   CLEAR_COLOR = '0,
    parameter int                   FIFO_DEPTH  = 4,
    parameter int                   MAX_RD_RUN  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_valid,
    input  logic [15:0]        clr_x,
    input  logic [15:0]        clr_y,
    output logic               clr_ready,
    input  logic               pix_valid,
    input  logic [15:0]        pix_x,
    input  logic [15:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    output logic               pix_ready,
    input  logic               rd_valid,
    input  logic [15:0]        rd_x,
    input  logic [15:0]        rd_y,
    output logic               rd_ready,
    output logic               rd_data_valid,
    output logic [COLOR_W-1:0] rd_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic               busy,
    output logic [15:0]        drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

    function automatic logic [ADDR_W-1:0] xy_addr(input logic [15:0] x, input logic [15:0] y);
        return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    endfunction

    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [RUN_W-1:0]   rd_run_reg, rd_run_next;
    logic [15:0]        drop_count_reg;
    logic               rd_data_valid_reg;
    logic [ADDR_W-1:0]  entry_addr_reg  [FIFO_DEPTH];
    logic [COLOR_W-1:0] entry_color_reg [FIFO_DEPTH];

    logic fifo_empty, fifo_full, pix_fire, pix_oob, push, pop;
    logic write_pending, guard_active, grant_rd, grant_clr, grant_fifo;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));

    // Negative coordinates show up as the sign bit; the rest compare unsigned.
    assign pix_oob  = pix_x[15] | pix_y[15]
                    | ({16'd0, pix_x} >= 32'(WIDTH))
                    | ({16'd0, pix_y} >= 32'(HEIGHT));
    assign pix_fire = pix_valid && !fifo_full;
    assign push     = pix_fire && !pix_oob;

    assign write_pending = clr_valid || !fifo_empty;
    assign guard_active  = (rd_run_reg == RUN_W'(MAX_RD_RUN)) && write_pending;
    assign grant_rd      = rd_valid && !guard_active;
    assign grant_clr     = !grant_rd && clr_valid;
    assign grant_fifo    = !grant_rd && !clr_valid && !fifo_empty;
    assign pop           = grant_fifo;

    always_comb begin
        rd_run_next = rd_run_reg;
        if (grant_clr || grant_fifo)
            rd_run_next = '0;
        else if (grant_rd)
            rd_run_next = write_pending ? rd_run_reg + 1'b1 : '0;
    end

    // Outputs are forced idle while reset is held, independent of the flops.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_ready  = 1'b0;
        clr_ready = 1'b0;
        pix_ready = 1'b0;
        if (!rst) begin
            pix_ready = !fifo_full;
            if (grant_rd) begin
                mem_en   = 1'b1;
                mem_addr = xy_addr(rd_x, rd_y);
                rd_ready = 1'b1;
            end else if (grant_clr) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = xy_addr(clr_x, clr_y);
                mem_wdata = CLEAR_COLOR;
                clr_ready = 1'b1;
            end else if (grant_fifo) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = entry_addr_reg[rd_ptr_reg];
                mem_wdata = entry_color_reg[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            rd_run_reg        <= '0;
            drop_count_reg    <= '0;
            rd_data_valid_reg <= 1'b0;
        end else begin
            rd_run_reg        <= rd_run_next;
            rd_data_valid_reg <= grant_rd;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
            if (pix_fire && pix_oob && drop_count_reg != 16'hFFFF)
                drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    // Entry storage holds the precomputed address so the pop path is a plain mux.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PTR_W'(gi)) begin
                entry_addr_reg[gi]  <= xy_addr(pix_x, pix_y);
                entry_color_reg[gi] <= pix_color;
            end
        end
    end

    assign rd_data_valid = rd_data_valid_reg;
    assign rd_data       = rd_data_valid_reg ? mem_rdata : '0;
    assign busy          = !fifo_empty;
    assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: grant table plus multi-cycle corner sequences.
module tb_fb_port_arbiter;
    localparam int W = 640, H = 480, AW = 19, CW = 24;

    logic clk = 1'b0, rst = 1'b1;
    logic clr_valid = 0, pix_valid = 0, rd_valid = 0;
    logic [15:0] clr_x = 0, clr_y = 0, pix_x = 0, pix_y = 0, rd_x = 0, rd_y = 0;
    logic [CW-1:0] pix_color = 0, mem_rdata = 0;
    logic clr_ready, pix_ready, rd_ready, rd_data_valid, mem_en, mem_we, busy;
    logic [CW-1:0] rd_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    fb_port_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .COLOR_W(CW),
                      .CLEAR_COLOR('0), .FIFO_DEPTH(4), .MAX_RD_RUN(8)) dut (
        .clk(clk), .rst(rst),
        .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y), .clr_ready(clr_ready),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_ready(pix_ready),
        .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .drop_count(drop_count)
    );

    function automatic logic [CW-1:0] exp_rd(input logic [AW-1:0] a);
        return {5'b0, a} ^ 24'hA5C3E1;
    endfunction

    // SRAM stand-in: read data one cycle after the strobe, write log for later checks.
    int wr_cnt = 0;
    logic [AW-1:0] last_wa = '0;
    logic [CW-1:0] last_wd = '0;
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= exp_rd(mem_addr);
    end
    always @(posedge clk) begin
        if (!rst && mem_en && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else
            $display("ok   %s: %0h", name, act);
    endtask

    typedef struct {
        logic        rd_v;
        logic [15:0] rx, ry;
        logic        clr_v;
        logic [15:0] cx, cy;
        logic        e_en, e_we, e_rdy, e_crdy;
        logic [AW-1:0] e_addr;
    } vec_t;
    vec_t vecs[8];

    int wr0, pushes, nwr;
    bit seen_full;
    logic [15:0] bx[4], by[4];

    initial begin
        vecs[0] = '{1'b1, 16'd10,  16'd1,   1'b0, 16'd0,   16'd0,   1'b1, 1'b0, 1'b1, 1'b0, 19'd650};
        vecs[1] = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd5,   16'd0,   1'b1, 1'b1, 1'b0, 1'b1, 19'd5};
        vecs[2] = '{1'b0, 16'd0,   16'd0,   1'b0, 16'd0,   16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 19'd0};
        vecs[3] = '{1'b1, 16'd0,   16'd0,   1'b1, 16'd1,   16'd1,   1'b1, 1'b0, 1'b1, 1'b0, 19'd0};
        vecs[4] = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd639, 16'd479, 1'b1, 1'b1, 1'b0, 1'b1, 19'd307199};
        vecs[5] = '{1'b1, 16'd639, 16'd479, 1'b0, 16'd0,   16'd0,   1'b1, 1'b0, 1'b1, 1'b0, 19'd307199};
        vecs[6] = '{1'b1, 16'd3,   16'd2,   1'b1, 16'd9,   16'd9,   1'b1, 1'b0, 1'b1, 1'b0, 19'd1283};
        vecs[7] = '{1'b0, 16'd0,   16'd0,   1'b1, 16'd0,   16'd1,   1'b1, 1'b1, 1'b0, 1'b1, 19'd640};

        // Reset: requests asserted but every ready/strobe must stay low.
        rd_valid = 1; clr_valid = 1; pix_valid = 1;
        #12;
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_clr_ready", clr_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_rdv", rd_data_valid, 0);
        rd_valid = 0; clr_valid = 0; pix_valid = 0;
        @(negedge clk); rst = 0; #1;
        chk("idle_pix_ready", pix_ready, 1);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_addr", mem_addr, 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_valid = vecs[i].rd_v; rd_x = vecs[i].rx; rd_y = vecs[i].ry;
            clr_valid = vecs[i].clr_v; clr_x = vecs[i].cx; clr_y = vecs[i].cy;
            #1;
            chk($sformatf("vec%0d_en", i), mem_en, vecs[i].e_en);
            chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_rd_ready", i), rd_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_clr_ready", i), clr_ready, vecs[i].e_crdy);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_rdv", i), rd_data_valid, vecs[i].e_rdy);
            if (vecs[i].e_rdy)
                chk($sformatf("vec%0d_rdata", i), rd_data, exp_rd(vecs[i].e_addr));
        end
        @(negedge clk); rd_valid = 0; clr_valid = 0;

        // Single pixel: written the cycle after the push, busy clears after the pop.
        @(negedge clk);
        pix_valid = 1; pix_x = 3; pix_y = 2; pix_color = 24'hFF0000; #1;
        chk("pix_ready", pix_ready, 1);
        chk("pix_no_bypass", mem_en, 0);
        @(negedge clk); pix_valid = 0; #1;
        chk("pix_we", mem_we, 1);
        chk("pix_addr", mem_addr, 1283);
        chk("pix_wdata", mem_wdata, 24'hFF0000);
        chk("pix_busy", busy, 1);
        @(negedge clk); #1;
        chk("pix_busy_drop", busy, 0);
        chk("pix_idle", mem_en, 0);

        // Starvation guard: continuous reads, six pixels; one write every 9th cycle.
        pushes = 0; nwr = 0; seen_full = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            rd_valid = 1; rd_x = 20; rd_y = 0;
            pix_valid = (pushes < 6); pix_x = 16'(pushes); pix_y = 0;
            pix_color = 24'h001000 + 24'(pushes);
            #1;
            if (pushes == 4 && !seen_full) begin
                seen_full = 1;
                chk("starve_full", pix_ready, 0);
            end
            if (mem_en && mem_we) begin
                chk("starve_wr_cycle", c, 9 * (nwr + 1));
                chk("starve_rd_blocked", rd_ready, 0);
                chk("starve_wr_addr", mem_addr, nwr);
                nwr++;
            end else
                chk("starve_rd", rd_ready, 1);
            if (pix_valid && pix_ready) pushes++;
        end
        @(negedge clk); rd_valid = 0; pix_valid = 0; #1;
        chk("starve_nwr", nwr, 6);
        chk("starve_pushes", pushes, 6);
        chk("starve_busy", busy, 0);

        // Bounds check: three drops, only the corner pixel reaches memory.
        bx = '{16'hFFFF, 16'd640, 16'd0,   16'd639};
        by = '{16'd5,    16'd0,   16'd480, 16'd479};
        wr0 = wr_cnt;
        chk("drop_init", drop_count, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_valid = 1; pix_x = bx[i]; pix_y = by[i]; pix_color = 24'h123456; #1;
            chk($sformatf("bounds%0d_ready", i), pix_ready, 1);
        end
        @(negedge clk); pix_valid = 0;
        repeat (3) @(negedge clk);
        chk("drop_count3", drop_count, 3);
        chk("bounds_wr_cnt", wr_cnt - wr0, 1);
        chk("bounds_addr", last_wa, 307199);
        chk("bounds_wdata", last_wd, 24'h123456);

        // Clear outranks the FIFO; FIFO drains only once clr_valid drops.
        @(negedge clk);
        clr_valid = 1; clr_x = 7; clr_y = 0;
        pix_valid = 1; pix_x = 1; pix_y = 1; pix_color = 24'h111111; #1;
        chk("clrpri_ready0", clr_ready, 1);
        @(negedge clk); pix_x = 2; pix_color = 24'h222222; #1;
        chk("clrpri_ready1", clr_ready, 1);
        chk("clrpri_wdata", mem_wdata, 0);
        chk("clrpri_addr", mem_addr, 7);
        @(negedge clk); pix_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("clrpri_hold_ready", clr_ready, 1);
            chk("clrpri_hold_addr", mem_addr, 7);
            chk("clrpri_hold_busy", busy, 1);
            @(negedge clk);
        end
        clr_valid = 0; #1;
        chk("drain0_addr", mem_addr, 641);
        chk("drain0_wdata", mem_wdata, 24'h111111);
        chk("drain0_clr_ready", clr_ready, 0);
        @(negedge clk); #1;
        chk("drain1_addr", mem_addr, 642);
        chk("drain1_wdata", mem_wdata, 24'h222222);
        @(negedge clk); #1;
        chk("drain_busy", busy, 0);
        chk("drain_idle", mem_en, 0);

        // Reset mid-operation: three queued pixels and a read in flight.
        @(negedge clk);
        clr_valid = 1; clr_x = 0; clr_y = 0; pix_valid = 1; pix_y = 5; pix_color = 24'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            pix_x = 16'(5 + i);
            @(negedge clk);
        end
        clr_valid = 0; pix_valid = 0; rd_valid = 1; rd_x = 1; rd_y = 0; #1;
        chk("midrst_rd_ready", rd_ready, 1);
        chk("midrst_busy_pre", busy, 1);
        @(posedge clk); #1;
        chk("midrst_rdv_pre", rd_data_valid, 1);
        #1; rst = 1; rd_valid = 0; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rdv", rd_data_valid, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_drop", drop_count, 0);
        wr0 = wr_cnt;
        @(negedge clk); rst = 0;
        repeat (5) @(negedge clk);
        chk("midrst_no_write", wr_cnt - wr0, 0);
        chk("midrst_busy_post", busy, 0);

        // Drop counter saturation.
        wr0 = wr_cnt;
        @(negedge clk); pix_valid = 1; pix_x = 16'hFFFF; pix_y = 0;
        repeat (65535) @(posedge clk);
        #1;
        chk("drop_sat_edge", drop_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk); pix_valid = 0; #1;
        chk("drop_sat_hold", drop_count, 16'hFFFF);
        chk("drop_sat_no_write", wr_cnt - wr0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port wireframe frame-buffer SRAM between three requesters:
  - display scan-out reads;
  - the rasterizer's clear sweep;
  - Bresenham line-pixel writes.
- Line pixels go through a small FIFO and are bounds-checked before they reach memory.
- A starvation guard keeps continuous scan-out from blocking writes indefinitely.
- Sits between the rasterizer controller / Bresenham engine and the frame-buffer SRAM.

Parameters:
- WIDTH, `WIDTH, frame width in pixels.
- HEIGHT, `HEIGHT, frame height in pixels.
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- COLOR_W, 24, pixel data width.
- CLEAR_COLOR, 0, value written by clear requests.
- FIFO_DEPTH, 4, line-pixel FIFO entries (power of 2, >= 2).
- MAX_RD_RUN, 8, maximum consecutive read grants while a write is pending.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_valid  in  1  clear pixel request.
- clr_x  in  16  clear x coordinate, unsigned.
- clr_y  in  16  clear y coordinate, unsigned.
- clr_ready  out  1  clear request granted this cycle.
- pix_valid  in  1  line pixel request.
- pix_x  in  16  signed x.
- pix_y  in  16  signed y.
- pix_color  in  COLOR_W  pixel colour.
- pix_ready  out  1  FIFO can accept.
- rd_valid  in  1  scan-out read request.
- rd_x  in  16  read x.
- rd_y  in  16  read y.
- rd_ready  out  1  read granted this cycle.
- rd_data_valid  out  1  read data valid.
- rd_data  out  COLOR_W  read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  COLOR_W  write data.
- mem_rdata  in  COLOR_W  synchronous SRAM data, valid 1 cycle after a read strobe.
- busy  out  1  FIFO non-empty.
- drop_count  out  16  count of out-of-bounds pixels discarded.

Behaviour:
- Reset (rst high, asynchronous):
  - FIFO emptied; contents discarded mid-operation.
  - rd_run counter = 0; drop_count = 0; rd_data_valid = 0.
  - All ready/strobe outputs are 0 while rst is high.
- Handshakes: a transfer occurs when valid && ready on the same rising edge.
  - clr_ready, rd_ready and all mem_* outputs are combinational from the current requests and state.
  - pix_ready = !fifo_full, registered-state based; it does not depend on the same-cycle pop, so there is no fall-through when full.
- Per-cycle grant priority, exactly one memory access per cycle:
  1. read, if rd_valid and guard not active;
  2. clear, if clr_valid;
  3. FIFO head, if non-empty.
- Write pending = clr_valid || FIFO non-empty.
- Starvation guard:
  - rd_run increments on each read grant while a write is pending.
  - rd_run resets to 0 on any write grant, and when a read is granted with no write pending.
  - When rd_run == MAX_RD_RUN, the guard is active: rd_ready = 0 and the highest-priority write is granted; rd_run then returns to 0.
- Address = y*WIDTH + x, computed in ADDR_W bits.
- Read grant: mem_en=1, mem_we=0. The next cycle has rd_data_valid=1 and rd_data=mem_rdata. Latency is 1 cycle from grant, and reads issue back-to-back every cycle.
- Clear grant: mem_en=1, mem_we=1, mem_wdata=CLEAR_COLOR.
- FIFO pop: mem_en=1, mem_we=1, address and colour taken from the head entry; the pop happens on the same edge.
- No grant: mem_en=0, mem_we=0, address and wdata = 0.
- Bounds check at push: x<0, y<0, x>=WIDTH or y>=HEIGHT → the pixel is accepted (handshake completes) but not enqueued. drop_count increments, saturating at 16'hFFFF.
- FIFO boundaries:
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Push and pop when empty: the pushed entry is not popped the same cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- busy = FIFO occupancy != 0. The controller must see busy=0 before signalling triangle done.

Test Plan:
- Reset, then idle: all outputs 0. Push pix (3,2,24'hFF0000) with WIDTH=640 → next cycle mem_we=1, mem_addr=1283, mem_wdata=FF0000, busy drops the following cycle.
- Read (10,1) held 1 cycle → mem_en=1, mem_we=0, mem_addr=650; one cycle later rd_data_valid=1, rd_data=mem_rdata.
- rd_valid held high and 6 pixels pushed, MAX_RD_RUN=8, FIFO_DEPTH=4:
  - pix_ready low after 4 pushes;
  - exactly one write is granted every 9th cycle, with rd_ready=0 that cycle.
- Pixels (-1,5), (640,0), (0,480), (639,479) pushed → drop_count=3, only addr 307199 written. Force 65540 drops → drop_count stays 16'hFFFF.
- clr_valid and FIFO non-empty simultaneously, no read → clear granted first with wdata=CLEAR_COLOR; FIFO drains only after clr_valid drops.
- rst asserted with 3 FIFO entries and a read in flight → busy=0, rd_data_valid=0 immediately, and no memory write after rst releases.
